// File: rtl/misr_pkg.sv
// Shared types and the width-generic MISR next-state function for the signature engine.
package misr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPACT = 2'd1,
    DONE    = 2'd2
  } misr_state_t;

  // Widest signature supported by misr_next(); callers zero-extend into this width.
  localparam int MISR_MAX_W = 64;

  // One MISR step: shift up, fold the old top bit through the tap mask, XOR in the beat.
  function automatic logic [MISR_MAX_W-1:0] misr_next(
    input logic [MISR_MAX_W-1:0] s,
    input logic [MISR_MAX_W-1:0] poly,
    input logic [MISR_MAX_W-1:0] d,
    input int                    w
  );
    logic [MISR_MAX_W-1:0] n;
    logic                  fb;
    n    = '0;
    fb   = s[w-1];
    n[0] = (fb & poly[0]) ^ d[0];
    for (int i = 1; i < MISR_MAX_W; i++) begin
      if (i < w) n[i] = s[i-1] ^ (fb & poly[i]) ^ d[i];
    end
    return n;
  endfunction

endpackage

// File: rtl/misr_sig_engine_core.sv
// Signature register plus feedback XOR network; load has priority over enable.
module misr_core
  import misr_pkg::*;
#(
  parameter int               WIDTH = 10,
  parameter logic [WIDTH-1:0] POLY  = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] sig
);

  always_ff @(posedge clk) begin
    if (reset || load) begin
      sig <= SEED;
    end else if (en) begin
      sig <= WIDTH'(misr_next(MISR_MAX_W'(sig), MISR_MAX_W'(POLY), MISR_MAX_W'(d), WIDTH));
    end
  end

endmodule

// File: rtl/misr_sig_engine.sv
// BIST response compactor: counted window of beats folded into a MISR, then compared to golden.
// Optional MISR_MASK_EN adds in_mask, forcing masked response bits to 0 before compaction.
module misr_sig_engine
  import misr_pkg::*;
#(
  parameter int               WIDTH = 10,
  parameter logic [WIDTH-1:0] POLY  = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b0}},
  parameter int               CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] golden,
`ifdef MISR_MASK_EN
  input  logic [WIDTH-1:0] in_mask,
`endif
  output logic [WIDTH-1:0] signature,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  misr_state_t      state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [WIDTH-1:0] golden_q;
  logic [WIDTH-1:0] d;
  logic             load, en, golden_ld;

`ifdef MISR_MASK_EN
  assign d = in_data & ~in_mask;
`else
  assign d = in_data;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      golden_q <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (golden_ld) golden_q <= golden;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    load      = 1'b0;
    en        = 1'b0;
    golden_ld = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            load      = 1'b1;
            count_nxt = num_vectors;
            if (num_vectors == '0) begin
              state_nxt = DONE;
              golden_ld = 1'b1;
            end else begin
              state_nxt = COMPACT;
            end
          end
        end
        COMPACT: begin
          // count is always >= 1 here, so the decrement cannot wrap
          if (in_valid) begin
            en        = 1'b1;
            count_nxt = count - 1'b1;
            if (count == CNT_W'(1)) begin
              state_nxt = DONE;
              golden_ld = 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  misr_core #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .en    (en),
    .d     (d),
    .sig   (signature)
  );

  assign busy = (state == COMPACT);
  assign done = (state == DONE);
  // signature is frozen in DONE, so this compares the final value against golden taken at entry
  assign pass = done && (signature == golden_q);

endmodule

// File: tb/tb_misr_sig_engine.sv
// Randomized bench for misr_sig_engine against a shift-and-fold polynomial reference model.
module tb_misr_sig_engine;

  localparam int         W     = 10;
  localparam int         CW    = 16;
  localparam logic [9:0] POLY  = 10'h3FF;
  localparam logic [9:0] SEED  = 10'h000;

  logic          clk = 1'b0;
  logic          reset, start, abort, in_valid;
  logic [CW-1:0] num_vectors;
  logic [W-1:0]  in_data, golden;
`ifdef MISR_MASK_EN
  logic [W-1:0]  in_mask;
`endif
  logic [W-1:0]  signature;
  logic          busy, done, pass;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  misr_sig_engine #(.WIDTH(W), .POLY(POLY), .SEED(SEED), .CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .num_vectors (num_vectors),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .golden      (golden),
`ifdef MISR_MASK_EN
    .in_mask     (in_mask),
`endif
    .signature   (signature),
    .busy        (busy),
    .done        (done),
    .pass        (pass)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: treat the signature as a polynomial, multiply by x, reduce by POLY, add the beat.
  function automatic logic [W-1:0] fold(input logic [W-1:0] s, input logic [W-1:0] d);
    int unsigned v;
    v = (int'(s) * 2);
    if (v >= (1 << W)) v = (v - (1 << W)) ^ int'(POLY);
    return W'(v) ^ d;
  endfunction

  task automatic do_start(input int n, input logic [W-1:0] gold);
    start = 1'b1; num_vectors = CW'(n); golden = gold;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic beat(input logic [W-1:0] dat);
    in_valid = 1'b1; in_data = dat;
    @(negedge clk);
    in_valid = 1'b0; in_data = W'($urandom);
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) @(negedge clk);
  endtask

  logic [W-1:0] exp_sig, ref3;
  logic [W-1:0] dq[$];

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    num_vectors = '0; in_data = '0; golden = '0;
`ifdef MISR_MASK_EN
    in_mask = '0;
`endif
    idle_cycles(2);
    chk("reset_sig", signature, SEED);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_pass", pass, 0);
    reset = 1'b0;

    // beats in IDLE are ignored
    beat(10'h155);
    chk("idle_beat_ignored", signature, SEED);

    // single-beat window
    do_start(1, 10'h001);
    chk("t1_busy", busy, 1);
    beat(10'h001);
    chk("t1_sig", signature, 10'h001);
    chk("t1_done_next_cycle", done, 1);
    chk("t1_pass", pass, 1);

    // walking one through all stages, then feedback across all taps
    do_start(10, 10'h200);
    beat(10'h001);
    for (int i = 0; i < 9; i++) beat(10'h000);
    chk("t2_sig10", signature, 10'h200);
    chk("t2_pass", pass, 1);
    do_start(11, 10'h000);
    beat(10'h001);
    for (int i = 0; i < 10; i++) beat(10'h000);
    chk("t2_sig11", signature, 10'h3FF);
    chk("t2_fail_pass", pass, 0);

    // gaps of two idle cycles match the gapless reference
    ref3 = SEED;
    dq = {10'h0A5, 10'h3C1, 10'h27E};
    foreach (dq[i]) ref3 = fold(ref3, dq[i]);
    do_start(3, ref3);
    foreach (dq[i]) begin
      beat(dq[i]);
      if (i < 2) begin
        idle_cycles(2);
        chk("t3_busy_gap", busy, 1);
      end
    end
    chk("t3_sig", signature, ref3);
    chk("t3_pass", pass, 1);
    // beat on the DONE-entry cycle is not compacted; golden change after entry has no effect
    golden = ~ref3;
    beat(10'h3FF);
    chk("t3_done_beat_ignored", signature, ref3);
    chk("t3_pass_held", pass, 1);

    // empty window from DONE
    do_start(0, 10'h000);
    chk("t4_done", done, 1);
    chk("t4_sig_seed", signature, SEED);
    chk("t4_pass", pass, 1);
    do_start(0, 10'h001);
    chk("t4_pass_mismatch", pass, 0);

    // abort mid-window; start while compacting leaves the count alone
    do_start(5, 10'h000);
    exp_sig = SEED;
    for (int i = 0; i < 2; i++) begin
      dq[0] = W'($urandom);
      exp_sig = fold(exp_sig, dq[0]);
      beat(dq[0]);
    end
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    chk("t5_abort_busy", busy, 0);
    chk("t5_abort_done", done, 0);
    chk("t5_abort_sig_held", signature, exp_sig);
    do_start(5, 10'h000);
    exp_sig = SEED;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) do_start(1, 10'h000);
      dq[0] = W'($urandom);
      exp_sig = fold(exp_sig, dq[0]);
      beat(dq[0]);
      if (i == 3) chk("t5_still_busy", busy, 1);
    end
    chk("t5_done_after5", done, 1);
    chk("t5_sig", signature, exp_sig);

    // abort and start together: abort wins
    abort = 1'b1; start = 1'b1; num_vectors = 16'd3;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    chk("abort_wins_busy", busy, 0);
    chk("abort_wins_done", done, 0);

    // randomized windows with random gaps and invalid-cycle garbage
    for (int k = 0; k < 8; k++) begin
      int n;
      logic [W-1:0] gold;
      n = $urandom_range(1, 14);
      dq.delete();
      exp_sig = SEED;
      for (int i = 0; i < n; i++) begin
        dq.push_back(W'($urandom));
        exp_sig = fold(exp_sig, dq[i]);
      end
      gold = ($urandom_range(0, 1) == 1) ? exp_sig : W'($urandom);
      do_start(n, gold);
      exp_sig = SEED;
      foreach (dq[i]) begin
        exp_sig = fold(exp_sig, dq[i]);
        beat(dq[i]);
        chk("rnd_sig", signature, exp_sig);
        if (i < n - 1) begin
          idle_cycles($urandom_range(0, 2));
          chk("rnd_busy", busy, 1);
        end
      end
      chk("rnd_done", done, 1);
      chk("rnd_pass", pass, (exp_sig == gold) ? 1 : 0);
    end

`ifdef MISR_MASK_EN
    // fully masked window leaves the seed untouched
    in_mask = '1;
    do_start(4, SEED);
    for (int i = 0; i < 4; i++) beat(W'($urandom));
    chk("t6_mask_sig", signature, SEED);
    chk("t6_mask_pass", pass, 1);
    in_mask = '0;
`endif

    // reset mid-window
    do_start(5, 10'h000);
    beat(10'h3A5);
    beat(10'h1C3);
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    chk("t6_rst_sig", signature, SEED);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_pass", pass, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
